// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e        : FSM state encodings driven out on pc_fetch_unit.state
//   CAUSE_*              : fault_cause codes
//   DEFAULT_RESET_VECTOR : first fetch byte address after reset
//   DEFAULT_TEXT_LIMIT   : highest legal fetch byte address (1024 words)
//   target_check()       : classifies a redirect target as legal, misaligned or out of range
package riscv_fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_RANGE      = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_LIMIT   = 32'h0000_0FFC;

    // Misalignment is reported ahead of range so a target that is both
    // gets the more specific diagnosis.
    function automatic logic [1:0] target_check(input logic [31:0] target,
                                                input logic [31:0] limit);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        if (target[1:0] != 2'b00) begin
            cause = CAUSE_MISALIGNED;
        end else if (target > limit) begin
            cause = CAUSE_RANGE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Instruction hold register for downstream stalls.
// Memory keeps reading the (unchanged) PC during a stall, so its read data
// moves on to the next word; this buffer freezes the word decode is looking at.
//   clk, rst    : clock, synchronous active-high reset
//   capture     : stall edge - latch the current instr_out and raise the hold flag
//   instr_in    : registered read data from instruction memory
//   instr_out   : held word while the flag is set, otherwise instr_in
//   hold_active : hold flag
module fetch_hold_buffer
    import riscv_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               hold_active
);

    logic [INSTR_W-1:0] hold_data_reg;
    logic               hold_flag_reg;

    assign instr_out   = hold_flag_reg ? hold_data_reg : instr_in;
    assign hold_active = hold_flag_reg;

    // Re-capturing instr_out on every stalled edge is harmless: once the flag
    // is up instr_out already is the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_reg <= '0;
            hold_flag_reg <= 1'b0;
        end else begin
            hold_flag_reg <= capture;
            if (capture) begin
                hold_data_reg <= instr_out;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer (RUN / HALT / FAULT).
//   clk, rst            : clock, synchronous active-high reset
//   stall               : downstream hold request
//   redirect_valid/target : taken branch/jump and its byte address
//   halt_req            : stop fetching
//   instr_in            : registered instruction memory read data (1-cycle latency)
//   PC_out_address      : fetch address, live when fetch_req=1
//   instr_out/instr_pc/instr_valid : instruction to decode, its address, qualifier
//   pc_plus4            : instr_pc + 4 for link writeback
//   fault/fault_cause   : sticky fetch fault and its reason
//   state               : current FSM encoding
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TEXT_LIMIT   = DEFAULT_TEXT_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic [31:0] instr_in,
    output logic [31:0] PC_out_address,
    output logic        fetch_req,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [1:0]  state
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  instr_pc_reg, instr_pc_next;
    logic         instr_valid_reg, instr_valid_next;
    logic         fault_reg, fault_next;
    logic [1:0]   fault_cause_reg, fault_cause_next;
    logic         hold_capture;
    logic         hold_active;
    logic [32:0]  seq_sum;
    logic [1:0]   target_code;
    logic [1:0]   seq_code;

    fetch_hold_buffer u_hold (
        .clk         (clk),
        .rst         (rst),
        .capture     (hold_capture),
        .instr_in    (instr_in),
        .instr_out   (instr_out),
        .hold_active (hold_active)
    );

    assign PC_out_address = pc_reg;
    assign fetch_req      = (state_reg == ST_RUN) && !rst;
    assign instr_pc       = instr_pc_reg;
    assign instr_valid    = instr_valid_reg;
    assign pc_plus4       = instr_pc_reg + 32'd4;
    assign fault          = fault_reg;
    assign fault_cause    = fault_cause_reg;
    assign state          = state_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        fault_next       = fault_reg;
        fault_cause_next = fault_cause_reg;
        hold_capture     = 1'b0;

        // The carry bit catches wrap past 2^32 as out of range.
        seq_sum     = {1'b0, pc_reg} + 33'd4;
        seq_code    = (seq_sum[32] || (seq_sum[31:0] > TEXT_LIMIT)) ? CAUSE_RANGE : CAUSE_NONE;
        target_code = target_check(redirect_target, TEXT_LIMIT);

        case (state_reg)
            ST_RUN, ST_HALT: begin
                if (redirect_valid) begin
                    if (target_code != CAUSE_NONE) begin
                        state_next       = ST_FAULT;
                        fault_next       = 1'b1;
                        fault_cause_next = target_code;
                        instr_valid_next = 1'b0;
                    end else begin
                        // The word already in flight belongs to the old path.
                        state_next       = ST_RUN;
                        pc_next          = redirect_target;
                        instr_valid_next = 1'b0;
                    end
                end else if (state_reg == ST_RUN) begin
                    if (halt_req) begin
                        state_next       = ST_HALT;
                        instr_valid_next = 1'b0;
                    end else if (stall) begin
                        hold_capture = 1'b1;
                    end else if (seq_code != CAUSE_NONE) begin
                        state_next       = ST_FAULT;
                        fault_next       = 1'b1;
                        fault_cause_next = seq_code;
                        instr_valid_next = 1'b0;
                    end else begin
                        pc_next          = seq_sum[31:0];
                        instr_pc_next    = pc_reg;
                        instr_valid_next = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                // Only reset leaves FAULT.
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_RUN;
            pc_reg          <= RESET_VECTOR;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            fault_reg       <= 1'b0;
            fault_cause_reg <= CAUSE_NONE;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            fault_reg       <= fault_next;
            fault_cause_reg <= fault_cause_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, then
// randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam logic [31:0] LIMIT = DEFAULT_TEXT_LIMIT;
    localparam logic [31:0] RVEC  = DEFAULT_RESET_VECTOR;
    localparam logic [1:0]  R = ST_RUN;
    localparam logic [1:0]  H = ST_HALT;
    localparam logic [1:0]  F = ST_FAULT;

    logic        clk;
    logic        rst, stall, redirect_valid, halt_req;
    logic [31:0] redirect_target, instr_in;
    logic [31:0] PC_out_address, instr_out, instr_pc, pc_plus4;
    logic        fetch_req, instr_valid, fault;
    logic [1:0]  fault_cause, state;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .instr_in        (instr_in),
        .PC_out_address  (PC_out_address),
        .fetch_req       (fetch_req),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .pc_plus4        (pc_plus4),
        .fault           (fault),
        .fault_cause     (fault_cause),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory with registered read, driven by live fetches only.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (fetch_req === 1'b1) instr_in <= mem[PC_out_address[11:2]];
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [1:0]  m_state;
    logic [31:0] m_pc, m_ipc;
    bit          m_valid, m_fault;
    logic [1:0]  m_cause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_fault_to(input logic [1:0] c);
        m_state = F; m_fault = 1'b1; m_cause = c; m_valid = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rv,
                              input logic [31:0] t, input bit h);
        if (r) begin
            m_state = R; m_pc = RVEC; m_ipc = 0; m_valid = 0; m_fault = 0; m_cause = 0;
        end else if (m_state != F && rv) begin
            if (t % 4 != 0)      m_fault_to(2'b01);
            else if (t > LIMIT)  m_fault_to(2'b10);
            else begin m_state = R; m_pc = t; m_valid = 0; end
        end else if (m_state == R) begin
            if (h) begin
                m_state = H; m_valid = 0;
            end else if (!s) begin
                if ({1'b0, m_pc} + 33'd4 > {1'b0, LIMIT}) m_fault_to(2'b10);
                else begin m_ipc = m_pc; m_pc = m_pc + 4; m_valid = 1; end
            end
        end
    endtask

    task automatic apply(input bit r, input bit s, input bit rv,
                         input logic [31:0] t, input bit h);
        rst = r; stall = s; redirect_valid = rv; redirect_target = t; halt_req = h;
        @(posedge clk);
        model_edge(r, s, rv, t, h);
        #1;
    endtask

    typedef struct {
        bit          r, s, rv;
        logic [31:0] t;
        bit          h;
        logic [1:0]  es;
        logic [31:0] epc;
        bit          ef, ev;
        logic [31:0] eipc;
        bit          efl;
        logic [1:0]  ec;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit s, input bit rv, input logic [31:0] t,
                                input bit h, input logic [1:0] es, input logic [31:0] epc,
                                input bit ef, input bit ev, input logic [31:0] eipc,
                                input bit efl, input logic [1:0] ec);
        vec_t v;
        v.r = r; v.s = s; v.rv = rv; v.t = t; v.h = h; v.es = es; v.epc = epc;
        v.ef = ef; v.ev = ev; v.eipc = eipc; v.efl = efl; v.ec = ec;
        return v;
    endfunction

    vec_t vecs [36];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1; stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;

        //              r  s  rv target    h  state pc       fq v  ipc      flt cause
        vecs[0]  = mk(1, 0, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[1]  = mk(1, 0, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[2]  = mk(0, 0, 0, 32'h0,    0, R, 32'h4,    1, 1, 32'h0,    0, 2'd0);
        vecs[3]  = mk(0, 0, 0, 32'h0,    0, R, 32'h8,    1, 1, 32'h4,    0, 2'd0);
        vecs[4]  = mk(0, 1, 0, 32'h0,    0, R, 32'h8,    1, 1, 32'h4,    0, 2'd0);
        vecs[5]  = mk(0, 1, 0, 32'h0,    0, R, 32'h8,    1, 1, 32'h4,    0, 2'd0);
        vecs[6]  = mk(0, 1, 0, 32'h0,    0, R, 32'h8,    1, 1, 32'h4,    0, 2'd0);
        vecs[7]  = mk(0, 0, 0, 32'h0,    0, R, 32'hC,    1, 1, 32'h8,    0, 2'd0);
        vecs[8]  = mk(0, 1, 1, 32'h40,   0, R, 32'h40,   1, 0, 32'h8,    0, 2'd0);
        vecs[9]  = mk(0, 0, 0, 32'h0,    0, R, 32'h44,   1, 1, 32'h40,   0, 2'd0);
        vecs[10] = mk(0, 0, 0, 32'h0,    0, R, 32'h48,   1, 1, 32'h44,   0, 2'd0);
        vecs[11] = mk(0, 0, 0, 32'h0,    1, H, 32'h48,   0, 0, 32'h44,   0, 2'd0);
        vecs[12] = mk(0, 0, 0, 32'h0,    0, H, 32'h48,   0, 0, 32'h44,   0, 2'd0);
        vecs[13] = mk(0, 1, 0, 32'h0,    0, H, 32'h48,   0, 0, 32'h44,   0, 2'd0);
        vecs[14] = mk(0, 0, 1, 32'h10,   0, R, 32'h10,   1, 0, 32'h44,   0, 2'd0);
        vecs[15] = mk(0, 0, 0, 32'h0,    0, R, 32'h14,   1, 1, 32'h10,   0, 2'd0);
        vecs[16] = mk(0, 0, 1, 32'h42,   0, F, 32'h14,   0, 0, 32'h10,   1, 2'd1);
        vecs[17] = mk(0, 0, 0, 32'h0,    0, F, 32'h14,   0, 0, 32'h10,   1, 2'd1);
        vecs[18] = mk(0, 0, 1, 32'h40,   0, F, 32'h14,   0, 0, 32'h10,   1, 2'd1);
        vecs[19] = mk(1, 0, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[20] = mk(0, 0, 0, 32'h0,    0, R, 32'h4,    1, 1, 32'h0,    0, 2'd0);
        vecs[21] = mk(0, 0, 1, 32'h1000, 0, F, 32'h4,    0, 0, 32'h0,    1, 2'd2);
        vecs[22] = mk(1, 0, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[23] = mk(0, 0, 0, 32'h0,    0, R, 32'h4,    1, 1, 32'h0,    0, 2'd0);
        vecs[24] = mk(0, 0, 1, 32'hFFC,  0, R, 32'hFFC,  1, 0, 32'h0,    0, 2'd0);
        vecs[25] = mk(0, 0, 0, 32'h0,    0, F, 32'hFFC,  0, 0, 32'h0,    1, 2'd2);
        vecs[26] = mk(1, 1, 1, 32'h40,   1, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[27] = mk(0, 0, 1, 32'h20,   1, R, 32'h20,   1, 0, 32'h0,    0, 2'd0);
        vecs[28] = mk(0, 0, 0, 32'h0,    1, H, 32'h20,   0, 0, 32'h0,    0, 2'd0);
        vecs[29] = mk(1, 0, 0, 32'h0,    1, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[30] = mk(0, 1, 0, 32'h0,    0, R, 32'h0,    1, 0, 32'h0,    0, 2'd0);
        vecs[31] = mk(1, 1, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);
        vecs[32] = mk(0, 0, 0, 32'h0,    0, R, 32'h4,    1, 1, 32'h0,    0, 2'd0);
        vecs[33] = mk(0, 0, 0, 32'h0,    1, H, 32'h4,    0, 0, 32'h0,    0, 2'd0);
        vecs[34] = mk(0, 0, 1, 32'h6,    0, F, 32'h4,    0, 0, 32'h0,    1, 2'd1);
        vecs[35] = mk(1, 0, 0, 32'h0,    0, R, 32'h0,    0, 0, 32'h0,    0, 2'd0);

        for (int i = 0; i < 36; i++) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].rv, vecs[i].t, vecs[i].h);
            $display("vec %0d rst=%0b stall=%0b redir=%0b tgt=%h halt=%0b -> state=%0d pc=%h fq=%0b v=%0b ipc=%h fault=%0b cause=%0d",
                     i, vecs[i].r, vecs[i].s, vecs[i].rv, vecs[i].t, vecs[i].h,
                     state, PC_out_address, fetch_req, instr_valid, instr_pc, fault, fault_cause);
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].es));
            check($sformatf("vec%0d pc", i), PC_out_address, vecs[i].epc);
            check($sformatf("vec%0d fetch_req", i), 32'(fetch_req), 32'(vecs[i].ef));
            check($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].eipc);
            check($sformatf("vec%0d pc_plus4", i), pc_plus4, vecs[i].eipc + 32'd4);
            check($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].efl));
            check($sformatf("vec%0d fault_cause", i), 32'(fault_cause), 32'(vecs[i].ec));
            if (vecs[i].ev)
                check($sformatf("vec%0d instr_out", i), instr_out, mem[vecs[i].eipc[11:2]]);
        end

        // Randomized traffic against the model, starting from reset.
        apply(1, 0, 0, 32'h0, 0);
        for (int n = 0; n < 400; n++) begin
            bit r, s, rv, h;
            logic [31:0] t;
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            rv = ($urandom_range(0, 99) < 10);
            h  = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 9))
                0:       t = $urandom;
                1:       t = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
                2:       t = LIMIT - (32'($urandom_range(0, 3)) << 2);
                default: t = 32'($urandom_range(0, 1023)) << 2;
            endcase
            apply(r, s, rv, t, h);
            $display("rnd %0d rst=%0b stall=%0b redir=%0b tgt=%h halt=%0b -> state=%0d pc=%h v=%0b ipc=%h cause=%0d",
                     n, r, s, rv, t, h, state, PC_out_address, instr_valid, instr_pc, fault_cause);
            check($sformatf("rnd%0d state", n), 32'(state), 32'(m_state));
            check($sformatf("rnd%0d pc", n), PC_out_address, m_pc);
            check($sformatf("rnd%0d fetch_req", n), 32'(fetch_req), 32'(!r && m_state == R));
            check($sformatf("rnd%0d instr_valid", n), 32'(instr_valid), 32'(m_valid));
            check($sformatf("rnd%0d instr_pc", n), instr_pc, m_ipc);
            check($sformatf("rnd%0d pc_plus4", n), pc_plus4, m_ipc + 32'd4);
            check($sformatf("rnd%0d fault", n), 32'(fault), 32'(m_fault));
            check($sformatf("rnd%0d fault_cause", n), 32'(fault_cause), 32'(m_cause));
            if (m_valid)
                check($sformatf("rnd%0d instr_out", n), instr_out, mem[m_ipc[11:2]]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
